// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage instruction-memory reader.
// Latches the fetch PC, issues one request on a req/gnt/rvalid port, presents the
// returned word to decode and drives fetch_stall (inverted elsewhere into the PC enable).
// Misaligned PCs and memory timeouts raise sticky faults and park the block in FAULT.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   pcf                        current fetch PC
//   flush                      redirect; discard any fetch in flight
//   stall_d                    decode cannot accept the instruction this cycle
//   imem_req/addr              memory request and registered address
//   imem_gnt/rvalid/rdata      memory grant, read-data valid, read data
//   instr_f, instr_valid       fetched instruction (registered) and its valid flag
//   fetch_stall                1 = hold the PC register
//   misalign_fault, bus_fault  sticky fault flags, cleared only by reset
module imem_fetch_ctrl #(
  parameter logic [31:0] NOP_INSTR      = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcf,
  input  logic        flush,
  input  logic        stall_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic        instr_valid,
  output logic        fetch_stall,
  output logic        misalign_fault,
  output logic        bus_fault
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StLatch   = 3'd0,
    StIssue   = 3'd1,
    StWait    = 3'd2,
    StDeliver = 3'd3,
    StFault   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             bus_q, bus_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // The current ISSUE/WAIT cycle is the TIMEOUT_CYCLES-th one.
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    bus_d   = bus_q;

    unique case (state_q)
      StLatch: begin
        addr_d = pcf;
        if (pcf[1:0] != 2'b00) begin
          state_d = StFault;
          mis_d   = 1'b1;
        end else if (!flush) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          state_d = StFault;
          bus_d   = 1'b1;
        end else if (imem_gnt) begin
          // A granted request cannot be cancelled; remember to discard its data.
          state_d = StWait;
          if (flush) drop_d = 1'b1;
        end else if (flush) begin
          state_d = StLatch;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          state_d = StFault;
          bus_d   = 1'b1;
        end else if (imem_rvalid) begin
          if (drop_q || flush) begin
            state_d = StLatch;
          end else begin
            instr_d = imem_rdata;
            state_d = StDeliver;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      StDeliver: begin
        if (flush || !stall_d) state_d = StLatch;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StLatch;
      end
    endcase

    // Every new fetch starts with a fresh timeout budget and no pending discard.
    if (state_d == StLatch) begin
      cnt_d  = '0;
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLatch;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      bus_q   <= bus_d;
    end
  end

  assign imem_req       = (state_q == StIssue);
  assign imem_addr      = addr_q;
  assign instr_f        = instr_q;
  assign instr_valid    = (state_q == StDeliver);
  assign fetch_stall    = ~((state_q == StDeliver) && !stall_d);
  assign misalign_fault = mis_q;
  assign bus_fault      = bus_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl (TIMEOUT_CYCLES = 8).
// Delivered words are queued when the bench returns read data and popped when decode
// observes instr_valid.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcf;
  logic        flush;
  logic        stall_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic        instr_valid;
  logic        fetch_stall;
  logic        misalign_fault;
  logic        bus_fault;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .NOP_INSTR     (NOP),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pcf           (pcf),
    .flush         (flush),
    .stall_d       (stall_d),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_f       (instr_f),
    .instr_valid   (instr_valid),
    .fetch_stall   (fetch_stall),
    .misalign_fault(misalign_fault),
    .bus_fault     (bus_fault)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    flush       = 1'b0;
    stall_d     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    tick();
    reset = 1'b0;
  endtask

  // Starts in a LATCH cycle, ends in the DELIVER cycle. cyc counts LATCH as cycle 1.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data,
                           output int cyc, output logic [31:0] addr_seen);
    pcf = pc;
    cyc = 1;
    tick();
    cyc++;
    while (!imem_req && cyc < 16) begin
      tick();
      cyc++;
    end
    addr_seen = imem_addr;
    imem_gnt  = 1'b1;
    tick();
    cyc++;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    sb.push_back(data);
    tick();
    cyc++;
    imem_rvalid = 1'b0;
    if (!instr_valid) cyc = -1;
  endtask

  task automatic test_reset();
    logic [31:0] a, exp;
    int          cyc;
    pcf = '0;
    do_reset();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    n_cmp++; if (instr_f !== NOP) begin n_bad++; $display("FAIL rst_instr got %h want %h", instr_f, NOP); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    n_cmp++; if (fetch_stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall got %b want 1", fetch_stall); end
    n_cmp++; if ({misalign_fault, bus_fault} !== 2'b00) begin n_bad++; $display("FAIL rst_faults got %b want 00", {misalign_fault, bus_fault}); end
    run_fetch(32'h0, 32'h00500093, cyc, a);
    #1;
    n_cmp++; if (a !== 32'h0) begin n_bad++; $display("FAIL t1_addr got %h want 0", a); end
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL t1_latency got %0d want 4", cyc); end
    n_cmp++; if (fetch_stall !== 1'b0) begin n_bad++; $display("FAIL t1_stall got %b want 0", fetch_stall); end
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (instr_f !== exp) begin n_bad++; $display("FAIL t1_instr got %h want %h", instr_f, exp); end
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL t1_release got %b want 0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, exp, data;
    int          cyc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      data = 32'h00100093 + (i << 20);
      run_fetch(32'(i * 4), data, cyc, a);
      #1;
      n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL b2b_latency[%0d] got %0d want 4", i, cyc); end
      n_cmp++; if (a !== 32'(i * 4)) begin n_bad++; $display("FAIL b2b_addr[%0d] got %h want %h", i, a, i * 4); end
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      n_cmp++; if (instr_f !== exp) begin n_bad++; $display("FAIL b2b_instr[%0d] got %h want %h", i, instr_f, exp); end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] a, exp;
    int          cyc;
    do_reset();
    run_fetch(32'h4, 32'h00A00113, cyc, a);
    n_cmp++; if (a !== 32'h4) begin n_bad++; $display("FAIL hold_addr got %h want 4", a); end
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({instr_valid, fetch_stall} !== 2'b11) begin n_bad++; $display("FAIL hold_flags[%0d] got %b want 11", i, {instr_valid, fetch_stall}); end
      n_cmp++; if (instr_f !== 32'h00A00113) begin n_bad++; $display("FAIL hold_instr[%0d] got %h want 00a00113", i, instr_f); end
      tick();
    end
    stall_d = 1'b0;
    #1;
    n_cmp++; if ({instr_valid, fetch_stall} !== 2'b10) begin n_bad++; $display("FAIL hold_release got %b want 10", {instr_valid, fetch_stall}); end
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (instr_f !== exp) begin n_bad++; $display("FAIL hold_sb got %h want %h", instr_f, exp); end
    pcf = 32'h8;
    tick();
    n_cmp++; if ({instr_valid, fetch_stall, imem_req} !== 3'b010) begin n_bad++; $display("FAIL hold_latch got %b want 010", {instr_valid, fetch_stall, imem_req}); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_bad++; $display("FAIL hold_next got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); end
  endtask

  task automatic test_flush_wait();
    logic [31:0] exp;
    do_reset();
    pcf = 32'h10;
    tick();                                   // ISSUE
    imem_gnt = 1'b1;
    tick();                                   // WAIT
    imem_gnt = 1'b0;
    flush    = 1'b1;
    pcf      = 32'h20;
    tick();                                   // WAIT, drop pending
    flush       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wait_valid got %b want 0", instr_valid); end
    tick();                                   // LATCH
    imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_discard_valid got %b want 0", instr_valid); end
    n_cmp++; if (instr_f !== NOP) begin n_bad++; $display("FAIL flush_discard_instr got %h want %h", instr_f, NOP); end
    tick();                                   // ISSUE with new PC
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_bad++; $display("FAIL flush_newreq got req=%b addr=%h want req=1 addr=20", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00100093;
    sb.push_back(32'h00100093);
    tick();
    imem_rvalid = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (instr_valid !== 1'b1 || instr_f !== exp) begin n_bad++; $display("FAIL flush_refetch got v=%b %h want v=1 %h", instr_valid, instr_f, exp); end
    tick();
  endtask

  task automatic test_misalign();
    int req_seen;
    do_reset();
    pcf = 32'h00000006;
    tick();
    n_cmp++; if (misalign_fault !== 1'b1) begin n_bad++; $display("FAIL mis_flag got %b want 1", misalign_fault); end
    req_seen = 0;
    imem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      flush = i[0];
      pcf   = 32'h100;
      if (imem_req || !fetch_stall || instr_valid || !misalign_fault) req_seen++;
      tick();
    end
    flush    = 1'b0;
    imem_gnt = 1'b0;
    n_cmp++; if (req_seen !== 0) begin n_bad++; $display("FAIL mis_parked got %0d bad cycles want 0", req_seen); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({misalign_fault, bus_fault, fetch_stall} !== 3'b001) begin n_bad++; $display("FAIL mis_clear got %b want 001", {misalign_fault, bus_fault, fetch_stall}); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    pcf = 32'h40;
    tick();
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      tick();
    end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL tmo_cycles got %0d want 8", n); end
    n_cmp++; if ({bus_fault, misalign_fault} !== 2'b10) begin n_bad++; $display("FAIL tmo_flags got %b want 10", {bus_fault, misalign_fault}); end
    tick();
    tick();
    n_cmp++; if ({imem_req, fetch_stall, bus_fault} !== 3'b011) begin n_bad++; $display("FAIL tmo_parked got %b want 011", {imem_req, fetch_stall, bus_fault}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    do_reset();
    pcf = 32'h80;
    tick();
    imem_gnt = 1'b1;
    tick();                                   // WAIT
    imem_gnt = 1'b0;
    reset    = 1'b1;
    tick();                                   // reset taken
    reset       = 1'b0;
    pcf         = 32'h0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD0BAD;
    n_cmp++; if ({imem_req, instr_valid, fetch_stall} !== 3'b001 || imem_addr !== 32'h0 || instr_f !== NOP) begin
      n_bad++; $display("FAIL rmid_reset got req/v/st=%b addr=%h instr=%h want 001 0 %h", {imem_req, instr_valid, fetch_stall}, imem_addr, instr_f, NOP);
    end
    tick();                                   // LATCH ignored rvalid
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_fresh got req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, instr_valid);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00200113;
    sb.push_back(32'h00200113);
    tick();
    imem_rvalid = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (instr_valid !== 1'b1 || instr_f !== exp) begin n_bad++; $display("FAIL rmid_deliver got v=%b %h want v=1 %h", instr_valid, instr_f, exp); end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_hold();
    test_flush_wait();
    test_misalign();
    test_timeout();
    test_reset_mid();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_drain got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
